// File: rtl/kim_divider_nbit_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and width defaults.
package kim_div_pkg;

  localparam int DIV_W_DEF = 32;
  localparam int CNT_W_DEF = $clog2(DIV_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kim_divider_nbit_seq_if.sv
// Request/result bundle between the EX stage and the divider.
interface kim_divider_nbit_seq_if
  import kim_div_pkg::*;
#(
  parameter int W = DIV_W_DEF
) ();
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/kim_divider_nbit_seq_sub.sv
// Unsigned n-bit subtractor; borrow is set when a < b.
module kim_subtractor_nbit_p #(
  parameter int SUB_DATA_WIDTH = 33
) (
  input  logic [SUB_DATA_WIDTH-1:0] a,
  input  logic [SUB_DATA_WIDTH-1:0] b,
  output logic [SUB_DATA_WIDTH-1:0] y,
  output logic                      borrow
);
  assign {borrow, y} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/kim_divider_nbit_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// quotient to LO, remainder to HI.
module kim_divider_nbit_seq
  import kim_div_pkg::*;
#(
  parameter int DIV_DATA_WIDTH = DIV_W_DEF
) (
  input logic clk,
  input logic reset,
  kim_divider_nbit_seq_if.slave dif
);
  localparam int N  = DIV_DATA_WIDTH;
  localparam int CW = $clog2(N + 1);

  state_t        state;
  logic [N-1:0]  dvd, dvs, rem;
  logic [CW-1:0] cnt;
  logic          qneg, rneg;
  logic          busy_r, done_r, dbz_r;
  logic [N-1:0]  quo_r, rem_r;

  logic [N:0]    t, d;
  logic          brw;
  logic [N-1:0]  rem_nx, dvd_nx, q_fin, r_fin, a_mag, b_mag;

  assign t = {rem, dvd[N-1]};

  kim_subtractor_nbit_p #(.SUB_DATA_WIDTH(N + 1)) u_sub (
    .a      (t),
    .b      ({1'b0, dvs}),
    .y      (d),
    .borrow (brw)
  );

  // Quotient bits share the dividend register, entering at bit 0.
  always_comb begin
    rem_nx = brw ? t[N-1:0] : d[N-1:0];
    dvd_nx = {dvd[N-2:0], ~brw};
    q_fin  = qneg ? -dvd_nx : dvd_nx;
    r_fin  = rneg ? -rem_nx : rem_nx;
    a_mag  = (dif.is_signed && dif.a[N-1]) ? -dif.a : dif.a;
    b_mag  = (dif.is_signed && dif.b[N-1]) ? -dif.b : dif.b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (dif.start) begin
            busy_r <= 1'b1;
            if (dif.b == '0) begin
              // Divide-by-zero skips CALC and reports the MIPS-style result.
              state  <= DONE;
              done_r <= 1'b1;
              quo_r  <= '1;
              rem_r  <= dif.a;
              dbz_r  <= 1'b1;
            end else begin
              state <= CALC;
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              cnt   <= '0;
              qneg  <= dif.is_signed & (dif.a[N-1] ^ dif.b[N-1]);
              rneg  <= dif.is_signed & dif.a[N-1];
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            quo_r  <= q_fin;
            rem_r  <= r_fin;
            dbz_r  <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign dif.busy        = busy_r;
  assign dif.done        = done_r;
  assign dif.quotient    = quo_r;
  assign dif.remainder   = rem_r;
  assign dif.div_by_zero = dbz_r;

endmodule

// File: tb/tb_kim_divider_nbit_seq.sv
// Directed-vector bench for kim_divider_nbit_seq at N=32.
module tb_kim_divider_nbit_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  kim_divider_nbit_seq_if #(.W(32)) dif ();

  kim_divider_nbit_seq #(.DIV_DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a start so it is sampled on the next rising edge (end of cycle 0).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dif.start = 1'b1; dif.a = a; dif.b = b; dif.is_signed = s;
    @(posedge clk);
    #1 dif.start = 1'b0;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic busy_ok,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz);
    start_op(a, b, s);
    lat = -1; busy_ok = 1'b1; q = '0; r = '0; dbz = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (dif.busy !== 1'b1) busy_ok = 1'b0;
      if (dif.done === 1'b1) begin
        lat = c; q = dif.quotient; r = dif.remainder; dbz = dif.div_by_zero;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic        bok, dbz, seen;
    logic [31:0] q, r;

    vt[0]  = '{32'd100,       32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33};
    vt[1]  = '{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
    vt[2]  = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33};
    vt[3]  = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33};
    vt[4]  = '{32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 33};
    vt[5]  = '{32'd5,         32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1, 1};
    vt[6]  = '{32'd9,         32'd3,          1'b0, 32'd3,          32'd0,          1'b0, 33};
    vt[7]  = '{32'h80000000,  32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0, 33};
    vt[8]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0, 33};
    vt[9]  = '{32'd0,         32'd5,          1'b1, 32'd0,          32'd0,          1'b0, 33};
    vt[10] = '{32'hFFFFFFF9,  32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 1};
    vt[11] = '{32'd12345678,  32'd1000,       1'b0, 32'd12345,      32'd678,        1'b0, 33};

    dif.start = 1'b0; dif.is_signed = 1'b0; dif.a = '0; dif.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_done", 32'(dif.done), 32'd0);
    check("rst_dbz",  32'(dif.div_by_zero), 32'd0);
    check("rst_q",    dif.quotient, 32'd0);
    check("rst_r",    dif.remainder, 32'd0);

    foreach (vt[i]) begin
      do_div(vt[i].a, vt[i].b, vt[i].sgn, lat, bok, q, r, dbz);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("v%0d_q", i), q, vt[i].q);
      check($sformatf("v%0d_r", i), r, vt[i].r);
      check($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vt[i].dbz));
      check($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_idle", i), 32'({dif.busy, dif.done}), 32'd0);
    end

    // Start mid-operation is ignored.
    start_op(32'd1000, 32'd10, 1'b0);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 10) begin dif.start = 1'b1; dif.a = 32'd50; dif.b = 32'd5; end
      if (c == 11) dif.start = 1'b0;
      if (dif.done === 1'b1 && lat < 0) begin
        lat = c; q = dif.quotient; r = dif.remainder;
      end
    end
    check("ign_lat", 32'(lat), 32'd33);
    check("ign_q", q, 32'd100);
    check("ign_r", r, 32'd0);

    // Reset in the middle of CALC aborts with no done.
    start_op(32'd1000, 32'd7, 1'b0);
    seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 20) reset = 1'b1;
      if (c == 21) begin
        check("abort_busy", 32'(dif.busy), 32'd0);
        check("abort_q", dif.quotient, 32'd0);
        check("abort_r", dif.remainder, 32'd0);
        reset = 1'b0;
      end
      if (dif.done === 1'b1) seen = 1'b1;
    end
    check("abort_nodone", 32'(seen), 32'd0);

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    dif.start = 1'b1; dif.a = 32'd8; dif.b = 32'd0; reset = 1'b1;
    @(negedge clk);
    dif.start = 1'b0; reset = 1'b0;
    check("rststart_busy", 32'(dif.busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen = 1'b1;
    end
    check("rststart_quiet", 32'(seen), 32'd0);

    // Back-to-back: second start at cycle N+2 completes at 2N+3.
    start_op(32'd100, 32'd7, 1'b0);
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 34) begin dif.start = 1'b1; dif.a = 32'd9; dif.b = 32'd3; end
      if (c == 35) dif.start = 1'b0;
      if (dif.done === 1'b1) begin
        if (c == 33) check("b2b_q1", dif.quotient, 32'd14);
        else begin lat = c; q = dif.quotient; end
      end
    end
    check("b2b_lat", 32'(lat), 32'd67);
    check("b2b_q2", q, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
